wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Arbiter for the single register-file write port of the 8-bit MIPS core. The write port is shared between the in-order writeback stage and the multi-cycle multiplier. Multiplier results wait in a small buffer until the port is free. The block stalls the pipeline when the buffer is full or a buffered result has waited too long. It also reports pending destinations to the hazard unit.

## Interface
- DATA_W, 8, result and register data width
- ADDR_W, 3, register address width (8 registers, r0 hardwired zero)
- DEPTH, 2, multiplier result buffer entries (≥1)
- MAX_WAIT, 4, cycles a buffered result may be denied before it is forced through (≥1)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- pipe_valid  in  1  writeback stage holds a result this cycle
- pipe_addr  in  ADDR_W  writeback destination register
- pipe_data  in  DATA_W  writeback result (ans_wb)
- mul_valid  in  1  multiplier offers a result
- mul_addr  in  ADDR_W  multiplier destination register
- mul_data  in  DATA_W  multiplier product, low byte
- mul_ready  out  1  buffer accepts; transfer occurs when mul_valid && mul_ready
- stall  out  1  writeback stage must hold its result; combinational
- rf_we  out  1  register-file write enable, registered
- rf_waddr  out  ADDR_W  register-file write address, registered
- rf_wdata  out  DATA_W  register-file write data, registered
- pend_mask  out  2^ADDR_W  bit i set while any buffered entry targets register i; registered

## Operation
- Buffer: DEPTH-entry FIFO of {addr, data}. count ranges 0..DEPTH.
- mul_ready = !reset && count < DEPTH. There is no push-through when full, even if a pop occurs the same cycle.
- A multiplier transfer with mul_addr==0 is acknowledged and discarded; it is never enqueued.
- A pipeline result with pipe_addr==0 is treated as pipe_valid=0: no write and no stall.
- Grant, evaluated every cycle, in strict priority order:
  - FORCE: count==DEPTH, or age ≥ MAX_WAIT → grant buffer head.
  - PIPE: else if effective pipe_valid → grant pipeline.
  - DRAIN: else if count>0 → grant buffer head.
  - NONE: otherwise.
- stall = effective pipe_valid && grant != PIPE.
- On a buffer grant, pop the head. A push and a pop in the same cycle are both legal; count is unchanged.
- age counter:
  - cleared on reset, on pop, and while the buffer is empty;
  - otherwise increments each cycle the head is denied;
  - saturates at MAX_WAIT.
- Write ordering between the two sources is not resolved here. The hazard unit uses pend_mask to hold issue of any instruction that reads or writes a pending register.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, pend_mask=0, count=0, age=0, mul_ready=0, stall=0.
- Reset mid-operation discards all buffered results; no write is issued for them.
- Pipeline result granted in cycle N → rf_we=1 with its addr/data in cycle N+1.
- Multiplier result accepted in cycle N into an empty buffer with no pipeline traffic → DRAIN in N+1 → rf_we in N+2.
- pend_mask reflects buffer contents after the edge. A bit is set the cycle after the push and cleared the cycle after the pop.
- rf_we falls to 0 the cycle after a NONE grant. rf_waddr/rf_wdata hold their last values.
- A stalled pipeline keeps pipe_valid/addr/data stable. It is granted no later than MAX_WAIT+DEPTH cycles after the stall begins.

## Structure
- Package wb_arb_pkg holds:
  - DATA_W and ADDR_W defaults;
  - grant enum {GNT_NONE, GNT_PIPE, GNT_DRAIN, GNT_FORCE};
  - the buffer entry struct {addr, data}.
- One sub-module, wb_result_fifo: DEPTH-entry FIFO with count, head outputs, and pend_mask generation.
- Grant logic, age counter and output register live in wb_port_arbiter.

## Test plan
- Reset, then pipe_valid=1, addr=3, data=0xF0 → rf_we=1, waddr=3, wdata=0xF0 next cycle; stall=0.
- Idle pipeline; mul_valid pulse with addr=5, data=0x0F → pend_mask=0x20 next cycle; rf_we with 5/0x0F two cycles after the pulse; pend_mask=0 afterwards.
- Continuous pipe_valid (addr=1) with one mul result (addr=2) → mul is written after exactly MAX_WAIT denied cycles. stall=1 for exactly that one cycle, then the pipeline write resumes.
- Two back-to-back mul results while pipe_valid is held → mul_ready=0 when count=2. FORCE drains both; stall is asserted in each of those cycles.
- pipe addr=0 and mul addr=0 → no rf_we, no stall, mul_ready stays 1, pend_mask stays 0.
- Reset asserted with count=2 → next cycle count=0, pend_mask=0, rf_we=0; no buffered write ever appears.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
// The entry struct uses the package widths; arbiter instances keep DATA_W/ADDR_W at these values.
package wb_arb_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_DRAIN,
    GNT_FORCE
  } grant_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Multiplier result buffer: DEPTH-entry FIFO with occupancy and a registered
// mask of destination registers currently held in the buffer.
module wb_result_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  wb_entry_t            push_entry,
  input  logic                 pop,
  output logic [CNT_W-1:0]     count,
  output wb_entry_t            head,
  output logic [2**ADDR_W-1:0] pend_mask
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t            mem_q [DEPTH];
  wb_entry_t            mem_d [DEPTH];
  logic [DEPTH-1:0]     vld_q, vld_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [2**ADDR_W-1:0] pend_q, pend_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = ptr_inc(rd_ptr_q);
    end
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    // Mask follows the post-edge contents so a bit appears the cycle after the push.
    pend_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_d[i]) pend_d[mem_d[i].addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];
  assign pend_mask = pend_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between writeback and the multiplier.
// Buffered multiplier results are forced through when the buffer fills or the head waits MAX_WAIT cycles.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pipe_valid,
  input  logic [ADDR_W-1:0]    pipe_addr,
  input  logic [DATA_W-1:0]    pipe_data,
  input  logic                 mul_valid,
  input  logic [ADDR_W-1:0]    mul_addr,
  input  logic [DATA_W-1:0]    mul_data,
  output logic                 mul_ready,
  output logic                 stall,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [2**ADDR_W-1:0] pend_mask
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AGE_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0]  count;
  wb_entry_t         head;
  wb_entry_t         push_entry;
  logic              pipe_eff, push, pop, buf_empty;
  grant_e            grant;
  logic [AGE_W-1:0]  age_q, age_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  // Writes to r0 are architecturally void on both sources.
  assign pipe_eff   = !reset && pipe_valid && (pipe_addr != '0);
  assign mul_ready  = !reset && (count < CNT_W'(DEPTH));
  assign push       = mul_valid && mul_ready && (mul_addr != '0);
  assign buf_empty  = (count == '0);
  assign push_entry = '{addr: mul_addr, data: mul_data};

  wb_result_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .head       (head),
    .pend_mask  (pend_mask)
  );

  always_comb begin
    grant = GNT_NONE;
    if (!buf_empty && (count == CNT_W'(DEPTH) || age_q >= AGE_W'(MAX_WAIT))) begin
      grant = GNT_FORCE;
    end else if (pipe_eff) begin
      grant = GNT_PIPE;
    end else if (!buf_empty) begin
      grant = GNT_DRAIN;
    end
  end

  assign pop   = (grant == GNT_FORCE) || (grant == GNT_DRAIN);
  assign stall = pipe_eff && (grant != GNT_PIPE);

  always_comb begin
    age_d      = age_q;
    rf_we_d    = (grant != GNT_NONE);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pop || buf_empty) begin
      age_d = '0;
    end else if (age_q != AGE_W'(MAX_WAIT)) begin
      age_d = age_q + 1'b1;
    end
    if (grant == GNT_PIPE) begin
      rf_waddr_d = pipe_addr;
      rf_wdata_d = pipe_data;
    end else if (pop) begin
      rf_waddr_d = head.addr;
      rf_wdata_d = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      age_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      age_q      <= age_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected register-file writes go into a
// scoreboard queue tagged with their due cycle; a negedge monitor retires them.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       pipe_valid;
  logic [2:0] pipe_addr;
  logic [7:0] pipe_data;
  logic       mul_valid;
  logic [2:0] mul_addr;
  logic [7:0] mul_data;
  logic       mul_ready;
  logic       stall;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [7:0] pend_mask;

  wb_port_arbiter #(
    .DATA_W   (8),
    .ADDR_W   (3),
    .DEPTH    (2),
    .MAX_WAIT (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_valid (pipe_valid),
    .pipe_addr  (pipe_addr),
    .pipe_data  (pipe_data),
    .mul_valid  (mul_valid),
    .mul_addr   (mul_addr),
    .mul_data   (mul_data),
    .mul_ready  (mul_ready),
    .stall      (stall),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .pend_mask  (pend_mask)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_wr(input int c, input logic [2:0] a, input logic [7:0] dt);
    exp_t e;
    e.cyc  = c;
    e.addr = a;
    e.data = dt;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (rf_we !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: rf_we=%b addr=%0d data=0x%0h, expected no write (cycle %0d)",
                 rf_we, rf_waddr, rf_wdata, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_cycle", cyc, mon_e.cyc);
        check("wr_addr", {29'd0, rf_waddr}, {29'd0, mon_e.addr});
        check("wr_data", {24'd0, rf_wdata}, {24'd0, mon_e.data});
      end
    end
  end

  initial begin
    // Reset with live inputs: nothing may be accepted, stalled or written.
    reset      = 1'b1;
    pipe_valid = 1'b1; pipe_addr = 3'd3; pipe_data = 8'hAA;
    mul_valid  = 1'b1; mul_addr  = 3'd5; mul_data  = 8'h55;
    step();
    step();
    check("rst_rf_we", rf_we, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_pend", pend_mask, 0);
    check("rst_mul_ready", mul_ready, 0);
    check("rst_stall", stall, 0);

    // Single pipeline write, one-cycle latency.
    step();
    reset = 1'b0;
    pipe_valid = 1'b1; pipe_addr = 3'd3; pipe_data = 8'hF0;
    mul_valid  = 1'b0;
    expect_wr(cyc + 1, 3'd3, 8'hF0);
    #1;
    check("t1_stall", stall, 0);
    check("t1_mul_ready", mul_ready, 1);

    // Lone multiplier result on an idle pipeline: drained, written two cycles later.
    step();
    pipe_valid = 1'b0;
    mul_valid = 1'b1; mul_addr = 3'd5; mul_data = 8'h0F;
    expect_wr(cyc + 2, 3'd5, 8'h0F);
    #1;
    check("t2_mul_ready", mul_ready, 1);
    step();
    mul_valid = 1'b0;
    #1;
    check("t2_pend_set", pend_mask, 8'h20);
    check("t2_stall", stall, 0);
    step();
    check("t2_pend_clr", pend_mask, 0);

    // Continuous pipeline with one mul result: head forced after MAX_WAIT denials.
    d = 8'h10;
    for (int i = 0; i < 7; i++) begin
      step();
      pipe_valid = 1'b1; pipe_addr = 3'd1; pipe_data = d;
      mul_valid = (i == 0); mul_addr = 3'd2; mul_data = 8'h22;
      #1;
      check("t3_stall", stall, (i == 5));
      if (i == 0) check("t3_mul_ready", mul_ready, 1);
      if (i == 1 || i == 5) check("t3_pend_set", pend_mask, 8'h04);
      if (i == 6) check("t3_pend_clr", pend_mask, 0);
      if (i == 5) expect_wr(cyc + 1, 3'd2, 8'h22);
      else begin
        expect_wr(cyc + 1, 3'd1, d);
        d = d + 8'd1;
      end
    end
    step();
    pipe_valid = 1'b0; mul_valid = 1'b0;

    // Two back-to-back mul results under a held pipeline: full-force, then age-force.
    d = 8'h40;
    for (int i = 0; i < 9; i++) begin
      step();
      pipe_valid = 1'b1; pipe_addr = 3'd4; pipe_data = d;
      mul_valid = (i < 2);
      mul_addr  = (i == 0) ? 3'd6 : 3'd7;
      mul_data  = (i == 0) ? 8'h66 : 8'h77;
      #1;
      check("t4_stall", stall, (i == 2 || i == 7));
      if (i <= 2) check("t4_mul_ready", mul_ready, (i < 2));
      if (i == 2) check("t4_pend_full", pend_mask, 8'hC0);
      if (i == 3) check("t4_pend_one", pend_mask, 8'h80);
      if (i == 8) check("t4_pend_clr", pend_mask, 0);
      if (i == 2) expect_wr(cyc + 1, 3'd6, 8'h66);
      else if (i == 7) expect_wr(cyc + 1, 3'd7, 8'h77);
      else begin
        expect_wr(cyc + 1, 3'd4, d);
        d = d + 8'd1;
      end
    end

    // r0 destinations on both sources are void.
    for (int i = 0; i < 3; i++) begin
      step();
      pipe_valid = 1'b1; pipe_addr = 3'd0; pipe_data = 8'h55;
      mul_valid  = 1'b1; mul_addr  = 3'd0; mul_data  = 8'h99;
      #1;
      check("t5_stall", stall, 0);
      check("t5_mul_ready", mul_ready, 1);
      check("t5_pend", pend_mask, 0);
    end
    step();
    pipe_valid = 1'b0; mul_valid = 1'b0;
    check("t5_no_write", rf_we, 0);

    // Fill the buffer, then reset: buffered results must vanish.
    for (int i = 0; i < 3; i++) begin
      step();
      if (i < 2) begin
        pipe_valid = 1'b1; pipe_addr = 3'd3; pipe_data = 8'h30 + 8'(i);
        mul_valid = 1'b1; mul_addr = (i == 0) ? 3'd4 : 3'd5; mul_data = 8'hA0 + 8'(i);
        expect_wr(cyc + 1, 3'd3, 8'h30 + 8'(i));
        #1;
        check("t6_stall", stall, 0);
      end else begin
        check("t6_pend_full", pend_mask, 8'h30);
        reset = 1'b1; pipe_valid = 1'b0; mul_valid = 1'b0;
        #1;
        check("t6_rst_mul_ready", mul_ready, 0);
        check("t6_rst_stall", stall, 0);
      end
    end
    step();
    reset = 1'b0;
    check("t6_pend_clr", pend_mask, 0);
    check("t6_rf_we", rf_we, 0);
    #1;
    check("t6_mul_ready", mul_ready, 1);
    for (int i = 0; i < 10; i++) step();

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
